// File: rtl/data_axi_bridge_if.sv
// Bundle of the LSU-side req/addr_ok/data_ok port and the AXI4 read/write
// channels. The bridge takes the master view: it is the AXI initiator
// and drives addr_ok/data_ok/rdata back towards the LSU.
interface data_axi_bridge_if #(
    parameter int ADDR_W = 32
);
    // LSU side
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;
    // AXI read address / data
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata_axi;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    // AXI write address / data / response
    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata_axi;
    logic [3:0]        wstrb_axi;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [3:0]        bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req, addr, we, size, wstrb, wdata,
        output addr_ok, data_ok, rdata,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata_axi, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata_axi, wstrb_axi, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output req, addr, we, size, wstrb, wdata,
        input  addr_ok, data_ok, rdata,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata_axi, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata_axi, wstrb_axi, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/data_axi_bridge.sv
// Data-side bridge: accepts one single-beat LSU request at a time and
// turns it into a single AXI4 read (AR/R) or write (AW/W/B) transaction,
// then reports completion with a one-cycle data_ok pulse.
module data_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_axi_bridge_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t            state_r, state_n_s;
    logic              aw_done_r, aw_done_n_s;
    logic              w_done_r, w_done_n_s;

    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [1:0]        size_r;
    logic [3:0]        wstrb_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;

    logic              arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r, data_ok_r;
    logic              arvalid_n_s, rready_n_s, awvalid_n_s, wvalid_n_s, bready_n_s, data_ok_n_s;

    logic              accept_s;
    logic              ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
    logic              unused_s;

    assign accept_s = bus.req && resetn && (state_r == S_IDLE);
    assign ar_hs_s  = arvalid_r && bus.arready;
    assign r_hs_s   = rready_r  && bus.rvalid;
    assign aw_hs_s  = awvalid_r && bus.awready;
    assign w_hs_s   = wvalid_r  && bus.wready;
    assign b_hs_s   = bready_r  && bus.bvalid;

    // Response IDs, response codes and rlast carry no information for a single-beat, single-ID bridge.
    assign unused_s = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp};

    // Next-state logic plus the next values of the registered handshake outputs.
    always_comb begin
        state_n_s   = state_r;
        aw_done_n_s = aw_done_r;
        w_done_n_s  = w_done_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_n_s   = bus.we ? S_AW_W : S_AR;
                    aw_done_n_s = 1'b0;
                    w_done_n_s  = 1'b0;
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_AR: begin
                if (ar_hs_s) state_n_s = S_R;
                else         state_n_s = S_AR;
            end
            S_R: begin
                if (r_hs_s) state_n_s = S_RESP;
                else        state_n_s = S_R;
            end
            S_AW_W: begin
                // Either channel may finish first; count this cycle's handshakes too.
                aw_done_n_s = aw_done_r | aw_hs_s;
                w_done_n_s  = w_done_r  | w_hs_s;
                if (aw_done_n_s && w_done_n_s) state_n_s = S_B;
                else                           state_n_s = S_AW_W;
            end
            S_B: begin
                if (b_hs_s) state_n_s = S_RESP;
                else        state_n_s = S_B;
            end
            S_RESP: begin
                state_n_s = S_IDLE;
            end
            default: begin
                state_n_s = S_IDLE;
            end
        endcase
        arvalid_n_s = (state_n_s == S_AR);
        rready_n_s  = (state_n_s == S_R);
        awvalid_n_s = (state_n_s == S_AW_W) && !aw_done_n_s;
        wvalid_n_s  = (state_n_s == S_AW_W) && !w_done_n_s;
        bready_n_s  = (state_n_s == S_B);
        data_ok_n_s = (state_n_s == S_RESP);
    end

    // State, channel-done flags and registered handshake outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= S_IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            data_ok_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            aw_done_r <= aw_done_n_s;
            w_done_r  <= w_done_n_s;
            arvalid_r <= arvalid_n_s;
            rready_r  <= rready_n_s;
            awvalid_r <= awvalid_n_s;
            wvalid_r  <= wvalid_n_s;
            bready_r  <= bready_n_s;
            data_ok_r <= data_ok_n_s;
        end
    end

    // Request fields are captured on acceptance; the load word on the R beat.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r  <= '0;
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            wstrb_r <= 4'd0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
        end else begin
            if (accept_s) begin
                addr_r  <= bus.addr;
                we_r    <= bus.we;
                size_r  <= bus.size;
                wstrb_r <= bus.wstrb;
                wdata_r <= bus.wdata;
            end
            if (r_hs_s) begin
                rdata_r <= bus.rdata_axi;
            end
        end
    end

    // LSU side
    assign bus.addr_ok   = accept_s;
    assign bus.data_ok   = data_ok_r;
    assign bus.rdata     = rdata_r;

    // AXI read channels
    assign bus.arid      = AXI_ID;
    assign bus.araddr    = addr_r;
    assign bus.arlen     = 8'd0;
    assign bus.arsize    = {1'b0, size_r};
    assign bus.arburst   = 2'b01;
    assign bus.arvalid   = arvalid_r;
    assign bus.rready    = rready_r;

    // AXI write channels; we_r only steers the FSM, the write fields are always presented.
    assign bus.awid      = we_r ? AXI_ID : AXI_ID;
    assign bus.awaddr    = addr_r;
    assign bus.awlen     = 8'd0;
    assign bus.awsize    = {1'b0, size_r};
    assign bus.awburst   = 2'b01;
    assign bus.awvalid   = awvalid_r;
    assign bus.wdata_axi = wdata_r;
    assign bus.wstrb_axi = wstrb_r;
    assign bus.wlast     = 1'b1;
    assign bus.wvalid    = wvalid_r;
    assign bus.bready    = bready_r;

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: an AXI slave model with programmable per-channel
// wait states, a scoreboard of expected completions, and per-transaction
// latency / beat-count checks derived from the programmed wait states.
module tb_data_axi_bridge;

    logic clk;
    logic resetn;

    data_axi_bridge_if #(.ADDR_W(32)) bus ();

    data_axi_bridge #(.AXI_ID(4'd1), .ADDR_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_store;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];

    int checks   = 0;
    int failures = 0;
    int dok_cnt  = 0;
    int aw_hs_cnt = 0;
    int w_hs_cnt  = 0;

    // slave wait states (cycles of valid before ready / ready before valid)
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0;
    logic [31:0] ar_cap = 32'd0;

    // per-transaction observations filled by run_req
    int ar_cyc, aw_cyc, w_cyc, lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rfun(input logic [31:0] a);
        return a ^ 32'hC2AD_BEFF;
    endfunction

    // AXI slave model: decides ready/valid on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            bus.arready = 1'b0; bus.rvalid = 1'b0; bus.awready = 1'b0;
            bus.wready  = 1'b0; bus.bvalid = 1'b0;
            ar_n = 0; r_n = 0; aw_n = 0; w_n = 0; b_n = 0;
        end else begin
            if (bus.arvalid) begin
                if (ar_n >= ar_dly) bus.arready = 1'b1;
                else begin bus.arready = 1'b0; ar_n++; end
            end else begin bus.arready = 1'b0; ar_n = 0; end
            if (bus.rready) begin
                if (r_n >= r_dly) begin bus.rvalid = 1'b1; bus.rdata_axi = rfun(ar_cap); end
                else begin bus.rvalid = 1'b0; r_n++; end
            end else begin bus.rvalid = 1'b0; r_n = 0; end
            if (bus.awvalid) begin
                if (aw_n >= aw_dly) bus.awready = 1'b1;
                else begin bus.awready = 1'b0; aw_n++; end
            end else begin bus.awready = 1'b0; aw_n = 0; end
            if (bus.wvalid) begin
                if (w_n >= w_dly) bus.wready = 1'b1;
                else begin bus.wready = 1'b0; w_n++; end
            end else begin bus.wready = 1'b0; w_n = 0; end
            if (bus.bready) begin
                if (b_n >= b_dly) bus.bvalid = 1'b1;
                else begin bus.bvalid = 1'b0; b_n++; end
            end else begin bus.bvalid = 1'b0; b_n = 0; end
        end
    end

    // Handshake observer: captures the read address and counts write beats.
    always @(posedge clk) begin
        if (bus.arvalid && bus.arready) ar_cap = bus.araddr;
        if (bus.awvalid && bus.awready) aw_hs_cnt++;
        if (bus.wvalid && bus.wready)   w_hs_cnt++;
    end

    // Scoreboard: every data_ok pops the oldest expectation.
    always @(negedge clk) begin
        if (resetn && bus.data_ok) begin
            exp_t e;
            dok_cnt++;
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (!e.is_store) check_eq("sb_rdata", bus.rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from IDLE to completion; caller is at posedge+1 with the bridge idle.
    task automatic run_req(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] st, input logic [31:0] wd, input int exp_lat);
        exp_t e;
        int   dok0, aw0, w0;
        logic stable, done;
        e.is_store = w;
        e.rdata    = rfun(a);
        sb_q.push_back(e);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.size = sz; bus.wstrb = st; bus.wdata = wd;
        #1;
        check_eq({tag, "_addr_ok"}, 32'(bus.addr_ok), 32'd1);
        dok0 = dok_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0; lat = 0; stable = 1'b1; done = 1'b0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        while (!done && lat < 60) begin
            lat++;
            if (lat == 1) begin
                if (!w) check_eq({tag, "_ar_fields"},
                                 {15'd0, bus.arvalid, bus.arid, bus.arlen, bus.arsize, bus.arburst},
                                 {15'd0, 1'b1, 4'd1, 8'd0, 1'b0, sz, 2'b01});
                else    check_eq({tag, "_aw_fields"},
                                 {9'd0, bus.awvalid, bus.wvalid, bus.wlast, bus.wstrb_axi, bus.awid,
                                  bus.awlen, bus.awsize, bus.awburst},
                                 {9'd0, 1'b1, 1'b1, 1'b1, st, 4'd1, 8'd0, 1'b0, sz, 2'b01});
            end
            if (bus.arvalid) begin
                ar_cyc++;
                if (bus.araddr !== a || bus.arsize !== {1'b0, sz}) stable = 1'b0;
            end
            if (bus.awvalid) begin
                aw_cyc++;
                if (bus.awaddr !== a) stable = 1'b0;
            end
            if (bus.wvalid) begin
                w_cyc++;
                if (bus.wdata_axi !== wd) stable = 1'b0;
            end
            if (bus.addr_ok) stable = 1'b0;
            if (bus.data_ok) done = 1'b1;
            else             tick();
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_stable"}, 32'(stable), 32'd1);
        tick();
        check_eq({tag, "_pulse"}, {31'd0, bus.data_ok}, 32'd0);
        check_eq({tag, "_dok_count"}, dok_cnt - dok0, 32'd1);
        if (w) begin
            check_eq({tag, "_aw_beats"}, aw_hs_cnt - aw0, 32'd1);
            check_eq({tag, "_w_beats"}, w_hs_cnt - w0, 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        logic ok;
        int   n, dok0;
        resetn = 1'b0;
        bus.req = 1'b0; bus.addr = 32'd0; bus.we = 1'b0; bus.size = 2'd0;
        bus.wstrb = 4'd0; bus.wdata = 32'd0;
        bus.arready = 1'b0; bus.rid = 4'd0; bus.rdata_axi = 32'd0; bus.rresp = 2'd0;
        bus.rlast = 1'b1; bus.rvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bid = 4'd0; bus.bresp = 2'd0; bus.bvalid = 1'b0;
        repeat (3) tick();

        // reset state
        check_eq("reset_outputs",
                 {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_ok, bus.addr_ok},
                 32'd0);
        check_eq("reset_rdata", bus.rdata, 32'd0);
        resetn = 1'b1;
        tick();

        // 1: zero-wait load word
        run_req("load_word", 1'b0, 32'h1C00_0010, 2'd2, 4'd0, 32'd0, 3);
        check_eq("load_word_ar_cyc", ar_cyc, 32'd1);
        check_eq("load_word_data", rfun(32'h1C00_0010), 32'hDEAD_BEEF);

        // 2: store byte, awready 3 cycles late, wready immediate
        aw_dly = 3;
        run_req("store_byte", 1'b1, 32'h0000_0003, 2'd0, 4'b1000, 32'h5A5A_5A5A, 6);
        check_eq("store_byte_aw_cyc", aw_cyc, 32'd4);
        check_eq("store_byte_w_cyc", w_cyc, 32'd1);
        aw_dly = 0;

        // 3: load with slow arready and slow rvalid
        ar_dly = 5; r_dly = 4;
        run_req("load_slow", 1'b0, 32'h8000_1234, 2'd1, 4'd0, 32'd0, 12);
        check_eq("load_slow_ar_cyc", ar_cyc, 32'd6);
        ar_dly = 0; r_dly = 0;

        // 6: AW and W together, then W lagging AW
        run_req("store_same", 1'b1, 32'h0000_0040, 2'd2, 4'b1111, 32'h1234_5678, 3);
        check_eq("store_same_cyc", {aw_cyc[15:0], w_cyc[15:0]}, {16'd1, 16'd1});
        w_dly = 2;
        run_req("store_wlag", 1'b1, 32'h0000_0082, 2'd1, 4'b1100, 32'hA1B2_C3D4, 5);
        check_eq("store_wlag_cyc", {aw_cyc[15:0], w_cyc[15:0]}, {16'd1, 16'd3});
        w_dly = 0;

        // 4: back-to-back loads with req held high
        e.is_store = 1'b0; e.rdata = rfun(32'h0000_1000); sb_q.push_back(e);
        e.is_store = 1'b0; e.rdata = rfun(32'h0000_2004); sb_q.push_back(e);
        dok0 = dok_cnt;
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.addr = 32'h0000_1000;
        #1;
        check_eq("b2b_first_addr_ok", 32'(bus.addr_ok), 32'd1);
        tick();
        bus.addr = 32'h0000_2004;
        ok = 1'b1; n = 0;
        while (!bus.data_ok && n < 30) begin
            if (bus.addr_ok) ok = 1'b0;
            n++;
            tick();
        end
        if (bus.addr_ok) ok = 1'b0;
        check_eq("b2b_first_done", 32'(bus.data_ok), 32'd1);
        check_eq("b2b_no_early_addr_ok", 32'(ok), 32'd1);
        tick();
        check_eq("b2b_second_addr_ok", 32'(bus.addr_ok), 32'd1);
        tick();
        bus.req = 1'b0;
        n = 0;
        while (!bus.data_ok && n < 30) begin n++; tick(); end
        tick();
        check_eq("b2b_dok_count", dok_cnt - dok0, 32'd2);
        check_eq("b2b_sb_drained", sb_q.size(), 32'd0);

        // 5: reset while waiting in B
        b_dly = 10;
        e.is_store = 1'b1; e.rdata = 32'd0; sb_q.push_back(e);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0100; bus.size = 2'd2;
        bus.wstrb = 4'hF; bus.wdata = 32'hCAFE_F00D;
        tick();
        bus.req = 1'b0;
        n = 0;
        while (!bus.bready && n < 20) begin n++; tick(); end
        check_eq("rst_reached_b", 32'(bus.bready), 32'd1);
        tick();
        bus.req = 1'b1;
        resetn = 1'b0;
        #1;
        check_eq("rst_async_outputs",
                 {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.data_ok, bus.addr_ok},
                 32'd0);
        check_eq("rst_no_completion", sb_q.size(), 32'd1);
        bus.req = 1'b0;
        sb_q.delete();
        b_dly = 0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run_req("after_rst", 1'b0, 32'h0000_0200, 2'd2, 4'd0, 32'd0, 3);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
